// File: rtl/abft_matrix_stream_corrector_pkg.sv
// ---------------------------------------------------------------------------------------------
// abft_pkg
//   Shared types for the ABFT matrix stream corrector.
//   status_e : frame classification reported alongside the replayed rows.
//   state_e  : corrector control states (load frame, classify, repair, replay).
// ---------------------------------------------------------------------------------------------
package abft_pkg;

    typedef enum logic [1:0] {
        ST_CLEAN = 2'd0,  // no syndrome set
        ST_CORR  = 2'd1,  // single data element repaired
        ST_CHK   = 2'd2,  // a single row or column check word was wrong
        ST_UNCOR = 2'd3   // pattern cannot be attributed to one element
    } status_e;

    typedef enum logic [1:0] {
        S_LOAD,
        S_CHECK,
        S_FIX,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/abft_matrix_stream_corrector_if.sv
// ---------------------------------------------------------------------------------------------
// abft_matrix_stream_corrector_if
//   Input/output stream bundle of the ABFT corrector.
//   in_valid/in_ready/in_data/in_rpar : one matrix row (or the column-parity word) per beat.
//   out_valid/out_ready/out_data/out_last : corrected row replay.
//   status/err_row/err_col : frame classification, stable through the replay.
//   master : traffic source/sink (testbench or upstream/downstream logic).
//   slave  : the corrector itself.
// ---------------------------------------------------------------------------------------------
interface abft_matrix_stream_corrector_if #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned W    = 8
);

    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CLW = $clog2(COLS);

    logic                in_valid;
    logic                in_ready;
    logic [COLS*W-1:0]   in_data;
    logic [W-1:0]        in_rpar;
    logic                out_valid;
    logic                out_ready;
    logic [COLS*W-1:0]   out_data;
    logic                out_last;
    logic [1:0]          status;
    logic [RW-1:0]       err_row;
    logic [CLW-1:0]      err_col;

    modport master (
        output in_valid, in_data, in_rpar, out_ready,
        input  in_ready, out_valid, out_data, out_last, status, err_row, err_col
    );

    modport slave (
        input  in_valid, in_data, in_rpar, out_ready,
        output in_ready, out_valid, out_data, out_last, status, err_row, err_col
    );

endinterface

// File: rtl/abft_matrix_stream_corrector_row_parity.sv
// ---------------------------------------------------------------------------------------------
// abft_row_parity
//   Combinational bitwise-XOR reduction of the COLS elements of one packed row.
//   row    : COLS*W packed row, element c at [c*W +: W]
//   parity : W-bit XOR of all elements
// ---------------------------------------------------------------------------------------------
module abft_row_parity #(
    parameter int unsigned COLS = 4,
    parameter int unsigned W    = 8
) (
    input  logic [COLS*W-1:0] row,
    output logic [W-1:0]      parity
);

    always_comb begin
        parity = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            parity = parity ^ row[c*W +: W];
        end
    end

endmodule

// File: rtl/abft_matrix_stream_corrector.sv
// ---------------------------------------------------------------------------------------------
// abft_matrix_stream_corrector
//   Buffers a ROWSxCOLS matrix frame (ROWS row beats with row parity, then one column-parity
//   beat), derives row/column syndromes, repairs a single-element error located at the
//   intersection of one failing row and one failing column, and replays the frame row by row.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards any partial frame
//   bus   : slave side of abft_matrix_stream_corrector_if (input beats, output rows, status)
// ---------------------------------------------------------------------------------------------
module abft_matrix_stream_corrector
    import abft_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned W    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    abft_matrix_stream_corrector_if.slave bus
);

    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CLW = $clog2(COLS);
    localparam int unsigned CW  = $clog2(ROWS + 1);
    localparam int unsigned NCW = $clog2(COLS + 1);

    localparam logic [CW-1:0] LastBeat = CW'(ROWS);
    localparam logic [CW-1:0] LastRow  = CW'(ROWS - 1);

    typedef logic [COLS*W-1:0] row_t;

    state_e          state_q;
    logic [CW-1:0]   beat_q;      // load beat index, reused as replay row index
    row_t            buffer_q [ROWS];
    logic [W-1:0]    acc_q    [COLS];
    logic [W-1:0]    rsyn_q   [ROWS];
    logic [W-1:0]    csyn_q   [COLS];

    // Classification captured in CHECK, published in FIX.
    status_e         cls_q;
    logic [RW-1:0]   cls_row_q;
    logic [CLW-1:0]  cls_col_q;

    status_e         status_q;
    logic [RW-1:0]   err_row_q;
    logic [CLW-1:0]  err_col_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    row_t            out_data_q;

    logic [W-1:0]    row_par;
    logic            in_fire;
    logic            out_fire;
    logic [RW-1:0]   beat_idx;

    abft_row_parity #(
        .COLS (COLS),
        .W    (W)
    ) u_row_parity (
        .row    (bus.in_data),
        .parity (row_par)
    );

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;
    assign beat_idx = beat_q[RW-1:0];

    // Syndrome census: how many rows/columns fail, and the first failing index of each.
    logic [CW-1:0]   nr;
    logic [NCW-1:0]  nc;
    logic [RW-1:0]   r_idx;
    logic [CLW-1:0]  c_idx;
    status_e         cls_d;
    logic [RW-1:0]   cls_row_d;
    logic [CLW-1:0]  cls_col_d;

    always_comb begin
        nr    = '0;
        nc    = '0;
        r_idx = '0;
        c_idx = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (rsyn_q[i] != '0) begin
                if (nr == '0) r_idx = RW'(i);
                nr = nr + CW'(1);
            end
        end
        for (int i = 0; i < int'(COLS); i++) begin
            if (csyn_q[i] != '0) begin
                if (nc == '0) c_idx = CLW'(i);
                nc = nc + NCW'(1);
            end
        end
    end

    always_comb begin
        cls_d     = ST_UNCOR;
        cls_row_d = '0;
        cls_col_d = '0;
        if (nr == '0 && nc == '0) begin
            cls_d = ST_CLEAN;
        end else if (nr == CW'(1) && nc == NCW'(1)) begin
            // One failing row and column only point at one element if both syndromes agree.
            if (rsyn_q[r_idx] == csyn_q[c_idx]) begin
                cls_d     = ST_CORR;
                cls_row_d = r_idx;
                cls_col_d = c_idx;
            end
        end else if (nr == CW'(1) && nc == '0) begin
            cls_d     = ST_CHK;
            cls_row_d = r_idx;
        end else if (nr == '0 && nc == NCW'(1)) begin
            cls_d     = ST_CHK;
            cls_col_d = c_idx;
        end
    end

    // Row selected by the classification with the syndrome folded into the failing element.
    row_t fixed_row;

    always_comb begin
        fixed_row = buffer_q[cls_row_q];
        fixed_row[cls_col_q*W +: W] = fixed_row[cls_col_q*W +: W] ^ rsyn_q[cls_row_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            beat_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            status_q    <= ST_CLEAN;
            err_row_q   <= '0;
            err_col_q   <= '0;
            cls_q       <= ST_CLEAN;
            cls_row_q   <= '0;
            cls_col_q   <= '0;
            for (int r = 0; r < int'(ROWS); r++) begin
                buffer_q[r] <= '0;
                rsyn_q[r]   <= '0;
            end
            for (int c = 0; c < int'(COLS); c++) begin
                acc_q[c]  <= '0;
                csyn_q[c] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_fire) begin
                        // Previous frame's report is retired by the first beat of the next frame.
                        if (beat_q == '0) begin
                            status_q  <= ST_CLEAN;
                            err_row_q <= '0;
                            err_col_q <= '0;
                        end
                        if (beat_q == LastBeat) begin
                            for (int c = 0; c < int'(COLS); c++) begin
                                csyn_q[c] <= acc_q[c] ^ bus.in_data[c*W +: W];
                            end
                            in_ready_q <= 1'b0;
                            beat_q     <= '0;
                            state_q    <= S_CHECK;
                        end else begin
                            buffer_q[beat_idx] <= bus.in_data;
                            rsyn_q[beat_idx]   <= row_par ^ bus.in_rpar;
                            for (int c = 0; c < int'(COLS); c++) begin
                                acc_q[c] <= acc_q[c] ^ bus.in_data[c*W +: W];
                            end
                            beat_q <= beat_q + CW'(1);
                        end
                    end
                end

                S_CHECK: begin
                    cls_q     <= cls_d;
                    cls_row_q <= cls_row_d;
                    cls_col_q <= cls_col_d;
                    state_q   <= S_FIX;
                end

                S_FIX: begin
                    status_q  <= cls_q;
                    err_row_q <= cls_row_q;
                    err_col_q <= cls_col_q;
                    if (cls_q == ST_CORR) begin
                        buffer_q[cls_row_q] <= fixed_row;
                    end
                    // Row 0 is presented in the same edge as the repair, so bypass the buffer.
                    if (cls_q == ST_CORR && cls_row_q == '0) begin
                        out_data_q <= fixed_row;
                    end else begin
                        out_data_q <= buffer_q[0];
                    end
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    beat_q      <= '0;
                    state_q     <= S_DRAIN;
                end

                S_DRAIN: begin
                    if (out_fire) begin
                        if (beat_q == LastRow) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            in_ready_q  <= 1'b1;
                            beat_q      <= '0;
                            for (int c = 0; c < int'(COLS); c++) begin
                                acc_q[c] <= '0;
                            end
                            state_q <= S_LOAD;
                        end else begin
                            out_data_q <= buffer_q[beat_idx + RW'(1)];
                            out_last_q <= ((beat_q + CW'(1)) == LastRow);
                            beat_q     <= beat_q + CW'(1);
                        end
                    end
                end

                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.status    = status_q;
    assign bus.err_row   = err_row_q;
    assign bus.err_col   = err_col_q;

endmodule

// File: tb/tb_abft_matrix_stream_corrector.sv
// ---------------------------------------------------------------------------------------------
// tb_abft_matrix_stream_corrector
//   Scoreboard bench: each frame is built as a 2-D element array, errors are injected
//   deliberately, and the expected replay (rows, status, location) follows from what was
//   injected. A monitor compares every presented row against the queue head.
// ---------------------------------------------------------------------------------------------
module tb_abft_matrix_stream_corrector;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned W    = 8;

    typedef logic [COLS*W-1:0] row_t;

    typedef struct packed {
        row_t       data;
        logic       last;
        logic [1:0] st;
        logic [1:0] er;
        logic [1:0] ec;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    abft_matrix_stream_corrector_if #(.ROWS(ROWS), .COLS(COLS), .W(W)) bus ();

    abft_matrix_stream_corrector #(
        .ROWS (ROWS),
        .COLS (COLS),
        .W    (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   ready_mode  = 0;
    int   ready_phase = 0;

    logic [W-1:0] orig [ROWS][COLS];
    logic [W-1:0] sent [ROWS][COLS];
    logic [W-1:0] rpar [ROWS];
    logic [W-1:0] cpar [COLS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic row_t pack_row(input int r, input bit use_orig);
        row_t v;
        for (int c = 0; c < int'(COLS); c++) begin
            v[c*W +: W] = use_orig ? orig[r][c] : sent[r][c];
        end
        return v;
    endfunction

    task automatic load_spec();
        int vals [16];
        vals = '{150, 200, 250, 180, 60, 80, 100, 72, 120, 160, 200, 144, 90, 120, 150, 108};
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                orig[r][c] = W'(vals[r*COLS + c]);
    endtask

    task automatic load_random();
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                orig[r][c] = W'($urandom_range(0, 255));
    endtask

    // Correct check words for the original matrix; injections then modify copies.
    task automatic make_clean();
        for (int r = 0; r < int'(ROWS); r++) rpar[r] = '0;
        for (int c = 0; c < int'(COLS); c++) cpar[c] = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                sent[r][c] = orig[r][c];
                rpar[r]    = rpar[r] ^ orig[r][c];
                cpar[c]    = cpar[c] ^ orig[r][c];
            end
        end
    endtask

    // A repaired frame replays the original matrix; every other class replays what was sent.
    task automatic expect_frame(input logic [1:0] st, input logic [1:0] er, input logic [1:0] ec);
        exp_t e;
        for (int r = 0; r < int'(ROWS); r++) begin
            e.data = pack_row(r, st == 2'd1);
            e.last = (r == int'(ROWS) - 1);
            e.st   = st;
            e.er   = er;
            e.ec   = ec;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input row_t d, input logic [W-1:0] p);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_rpar  = p;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("in_ready_wait", 64'(guard < 200), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame();
        row_t cw;
        for (int r = 0; r < int'(ROWS); r++) send_beat(pack_row(r, 1'b0), rpar[r]);
        for (int c = 0; c < int'(COLS); c++) cw[c*W +: W] = cpar[c];
        // Row parity on the column-parity beat is meaningless; send junk.
        send_beat(cw, W'($urandom_range(0, 255)));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_done", 64'(guard < 500), 64'd1);
    endtask

    // Downstream ready pattern generator.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                    ready_phase++;
                end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every presented row must match the queue head, held rows included.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                check("in_ready_low_in_drain", 64'(bus.in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    check("out_data", 64'(bus.out_data), 64'(e.data));
                    if (bus.out_ready) begin
                        check("out_last", 64'(bus.out_last), 64'(e.last));
                        check("status", 64'(bus.status), 64'(e.st));
                        check("err_row", 64'(bus.err_row), 64'(e.er));
                        check("err_col", 64'(bus.err_col), 64'(e.ec));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int typ, r1, c1, r2, c2;
        logic [W-1:0] m;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_rpar  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_status", 64'(bus.status), 64'd0);
        check("rst_err_row", 64'(bus.err_row), 64'd0);
        check("rst_err_col", 64'(bus.err_col), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: clean frame, with first-row latency check.
        load_spec();
        make_clean();
        expect_frame(2'd0, 2'd0, 2'd0);
        send_frame();
        check("lat_check_cycle", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_fix_cycle", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_drain_cycle", 64'(bus.out_valid), 64'd1);
        wait_drain();

        // 2: row1 element1 corrupted to 70 with the original row parity.
        load_spec();
        make_clean();
        sent[1][1] = 8'd70;
        expect_frame(2'd1, 2'd1, 2'd1);
        send_frame();
        wait_drain();

        // 3: column parity 2 bit 0 flipped.
        load_spec();
        make_clean();
        cpar[2] = cpar[2] ^ 8'h01;
        expect_frame(2'd2, 2'd0, 2'd2);
        send_frame();
        wait_drain();

        // 4: two data errors in different rows and columns.
        load_spec();
        make_clean();
        sent[0][0] = sent[0][0] ^ 8'h01;
        sent[2][3] = sent[2][3] ^ 8'h10;
        expect_frame(2'd3, 2'd0, 2'd0);
        send_frame();
        wait_drain();

        // 5: stalled replay with ready pattern 1,0,0,1.
        ready_mode  = 1;
        ready_phase = 0;
        load_random();
        make_clean();
        expect_frame(2'd0, 2'd0, 2'd0);
        send_frame();
        wait_drain();
        ready_mode = 0;

        // 6: reset after two load beats discards the partial frame.
        load_spec();
        make_clean();
        sent[3][2] = sent[3][2] ^ 8'h80;
        send_beat(pack_row(0, 1'b0), rpar[0]);
        send_beat(pack_row(1, 1'b0), rpar[1]);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_status", 64'(bus.status), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_spec();
        make_clean();
        expect_frame(2'd0, 2'd0, 2'd0);
        send_frame();
        wait_drain();

        // Randomized frames with random downstream backpressure, queued back to back.
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            load_random();
            make_clean();
            typ = $urandom_range(0, 4);
            r1  = $urandom_range(0, ROWS - 1);
            c1  = $urandom_range(0, COLS - 1);
            r2  = (r1 + 1 + $urandom_range(0, ROWS - 2)) % ROWS;
            c2  = (c1 + 1 + $urandom_range(0, COLS - 2)) % COLS;
            m   = W'($urandom_range(1, 255));
            case (typ)
                0: expect_frame(2'd0, 2'd0, 2'd0);
                1: begin
                    sent[r1][c1] = sent[r1][c1] ^ m;
                    expect_frame(2'd1, 2'(r1), 2'(c1));
                end
                2: begin
                    rpar[r1] = rpar[r1] ^ m;
                    expect_frame(2'd2, 2'(r1), 2'd0);
                end
                3: begin
                    cpar[c1] = cpar[c1] ^ m;
                    expect_frame(2'd2, 2'd0, 2'(c1));
                end
                default: begin
                    sent[r1][c1] = sent[r1][c1] ^ m;
                    sent[r2][c2] = sent[r2][c2] ^ W'($urandom_range(1, 255));
                    expect_frame(2'd3, 2'd0, 2'd0);
                end
            endcase
            send_frame();
        end
        wait_drain();
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
